// File: rtl/serial_word_comparator_pkg.sv
// serial_cmp_pkg: definitions shared by the serial word comparator.
//   state_t    - controller state encoding (IDLE, RUN, DONE)
//   CHAIN_INIT - {l,g,e} chain value at the start of a compare ("equal so far")
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] CHAIN_INIT = 3'b001;

endpackage

// File: rtl/serial_word_comparator_cell.sv
// cmp_bit_cell: combinational one-bit magnitude comparator step.
// Ports:
//   a, b       - current operand bits
//   li, gi, ei - incoming chain state (less / greater / equal so far)
//   lo, go, eo - outgoing chain state
// A decision already made higher up the word (li, then gi) wins. Only when
// the chain is still "equal" do the local bits decide the outcome.
module cmp_bit_cell (
   input  logic a,
   input  logic b,
   input  logic li,
   input  logic gi,
   input  logic ei,
   output logic lo,
   output logic go,
   output logic eo
);

   always_comb begin
      lo = 1'b0;
      go = 1'b0;
      eo = 1'b0;
      if (li) begin
         lo = 1'b1;
      end else if (gi) begin
         go = 1'b1;
      end else if (ei) begin
         lo = ~a & b;
         go = a & ~b;
         eo = ~(a ^ b);
      end
   end

endmodule

// File: rtl/serial_word_comparator.sv
// serial_word_comparator: compares two unsigned WIDTH-bit words one bit per
// clock, MSB first, through a single cmp_bit_cell.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - begin a compare (accepted in IDLE or DONE)
//   a, b       - operands, captured on the accepting edge
//   busy       - compare in progress
//   done       - one-cycle pulse, lt/gt/eq valid
//   lt, gt, eq - registered result, held until the next accepted start
// Build option: SERIAL_CMP_EARLY_EXIT_EN finishes as soon as the first
// differing bit is seen; otherwise every compare takes exactly WIDTH cycles.
module serial_word_comparator
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             gt,
   output logic             eq
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t          state, state_nxt;
   logic [WIDTH-1:0] sa, sb;
   logic [CW-1:0]    cnt;
   logic             cl, cg, ce;
   logic             lo, go, eo;
   logic             accept;
   logic             finish;

   cmp_bit_cell u_cell (
      .a  (sa[WIDTH-1]),
      .b  (sb[WIDTH-1]),
      .li (cl),
      .gi (cg),
      .ei (ce),
      .lo (lo),
      .go (go),
      .eo (eo)
   );

   // cnt == 1 means the bit in the cell this cycle is the LSB.
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign finish = (cnt == CW'(1)) | lo | go;
`else
   assign finish = (cnt == CW'(1));
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (finish) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            // A start here chains straight into the next compare.
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa           <= '0;
         sb           <= '0;
         cnt          <= '0;
         {cl, cg, ce} <= CHAIN_INIT;
         {lt, gt, eq} <= 3'b000;
      end else if (accept) begin
         sa           <= a;
         sb           <= b;
         cnt          <= CW'(WIDTH);
         {cl, cg, ce} <= CHAIN_INIT;
         {lt, gt, eq} <= 3'b000;
      end else if (state == RUN) begin
         {cl, cg, ce} <= {lo, go, eo};
         sa           <= sa << 1;
         sb           <= sb << 1;
         cnt          <= cnt - CW'(1);
         if (finish) {lt, gt, eq} <= {lo, go, eo};
      end
   end

endmodule
